risc_dmem_resp: RTL

RISC_DMEM_RESP -- requirements
Module: risc_dmem_resp

---
 rtl/risc_dmem_resp_if.sv | 28 ++
 rtl/risc_dmem_resp.sv | 118 +++++++++++
 2 files changed

// File: rtl/risc_dmem_resp_if.sv
// Bundle of CPU data-memory and preload-loader signals between requester and responder.
// Latency: none (wires only).
// Backpressure: the responder's ld_ready/busy tell the requester when bytes/accesses are taken.
interface risc_dmem_resp_if;
   logic       dmenbl;
   logic       rdwr;
   logic [3:0] dmaddr;
   logic [7:0] dmdatain;
   logic [7:0] dmdataout;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       ld_done;
   logic       busy;

   // CPU / loader side
   modport master (
      output dmenbl, rdwr, dmaddr, dmdatain, ld_start, ld_valid, ld_data,
      input  dmdataout, ld_ready, ld_done, busy
   );

   // memory responder side
   modport slave (
      input  dmenbl, rdwr, dmaddr, dmdatain, ld_start, ld_valid, ld_data,
      output dmdataout, ld_ready, ld_done, busy
   );
endinterface

// File: rtl/risc_dmem_resp.sv
// 16x8 CPU data memory with a RUN/LOAD FSM that accepts a 16-byte preload stream.
// Latency: reads return on dmdataout one cycle after the request; writes land at the request edge.
// Backpressure: during LOAD busy=1 and CPU accesses are dropped; loader bytes are taken whenever ld_valid=1.
// Optional DMEM_ACCESS_CNT_EN adds rd_cnt/wr_cnt counters of serviced RUN reads/writes.
module risc_dmem_resp #(
   parameter logic [7:0] INIT_VAL = 8'h00
) (
   input  logic           clk,
   input  logic           rst_n,
   risc_dmem_resp_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
   ,
   output logic [7:0]     rd_cnt,
   output logic [7:0]     wr_cnt
`endif
);

   typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [7:0] mem_q [16];
   logic [7:0] mem_d [16];
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] dout_q, dout_d;
   logic       ld_done_q, ld_done_d;

   // Next-state: CPU access in RUN (even on the ld_start cycle), byte capture in LOAD.
   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      ld_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.dmenbl) begin
               if (bus.rdwr) begin
                  dout_d = mem_q[bus.dmaddr];
               end else begin
                  mem_d[bus.dmaddr] = bus.dmdatain;
               end
            end
            if (bus.ld_start) begin
               state_d = LOAD;
               cnt_d   = 4'd0;
            end
         end
         LOAD: begin
            // ld_start is ignored here; gaps in ld_valid simply stall
            if (bus.ld_valid) begin
               mem_d[cnt_q] = bus.ld_data;
               cnt_d        = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d   = RUN;
                  ld_done_d = 1'b1;
               end
            end
         end
      endcase
   end

   // State, memory and output registers; reset wipes any partial preload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= 4'd0;
         dout_q    <= 8'h00;
         ld_done_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= INIT_VAL;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         ld_done_q <= ld_done_d;
         mem_q     <= mem_d;
      end
   end

   assign bus.dmdataout = dout_q;
   assign bus.ld_ready  = (state_q == LOAD);
   assign bus.busy      = (state_q == LOAD);
   assign bus.ld_done   = ld_done_q;

`ifdef DMEM_ACCESS_CNT_EN
   logic [7:0] rd_cnt_q, rd_cnt_d;
   logic [7:0] wr_cnt_q, wr_cnt_d;

   // Count only accesses actually serviced in RUN; 8-bit wrap is intentional.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (state_q == RUN && bus.dmenbl) begin
         if (bus.rdwr) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
         end else begin
            wr_cnt_d = wr_cnt_q + 8'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= 8'd0;
         wr_cnt_q <= 8'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

endmodule
